// File: rtl/pi_arb_pkg.sv
// pi_arb_pkg: shared types and destination codes for the PI/cartridge memory arbiter.
package pi_arb_pkg;
  typedef enum logic [1:0] {IDLE, CART, PI, RECOV} arb_state_t;
  typedef enum logic {G_CART, G_PI} grant_t;
  localparam logic [1:0] DST_PRG = 2'd0;
  localparam logic [1:0] DST_CHR = 2'd1;
  localparam logic [1:0] DST_SRM = 2'd2;
endpackage

// File: rtl/pi_act_sync.sv
// pi_act_sync: brings the spi_clk-domain PI strobe into clk and emits a 1-cycle pulse on its rising edge.
module pi_act_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic act,
  output logic rise
);
  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic lvl_q, lvl_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], act};
    lvl_d = sync_q[SYNC_STG-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q <= lvl_d;
    end
  end
  assign rise = sync_q[SYNC_STG-1] & ~lvl_q;
endmodule

// File: rtl/pi_mem_arb.sv
// pi_mem_arb: arbitrates the external memory port between mapper (cart) accesses and PI host accesses.
module pi_mem_arb
  import pi_arb_pkg::*;
#(
  parameter int MEM_AW   = 23,
  parameter int MEM_CYC  = 4,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pi_act,
  input  logic              pi_we,
  input  logic              pi_oe,
  input  logic              pi_mem,
  input  logic [24:0]       pi_addr,
  input  logic [7:0]        pi_dato,
  output logic [7:0]        pi_dati,
  output logic              pi_ovf,
  input  logic              cart_req,
  input  logic              cart_we,
  input  logic [1:0]        cart_sel,
  input  logic [MEM_AW-1:0] cart_addr,
  input  logic [7:0]        cart_dato,
  output logic [7:0]        cart_dati,
  output logic              cart_ack,
  output logic [1:0]        mem_sel,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              mem_ce,
  output logic              mem_oe,
  output logic              mem_we
);
  localparam int CW = $clog2(MEM_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_CYC - 1);
  arb_state_t state_q, state_d;
  grant_t last_q, last_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic pend_q, pend_d, ovf_q, ovf_d, ack_q, ack_d, we_q, we_d, rq_we_q, rq_we_d;
  logic [1:0] sel_q, sel_d, rq_sel_q, rq_sel_d;
  logic [MEM_AW-1:0] addr_q, addr_d, rq_addr_q, rq_addr_d;
  logic [7:0] dout_q, dout_d, rq_dato_q, rq_dato_d, pi_dati_q, pi_dati_d, cart_dati_q, cart_dati_d;
  logic pi_rise, pi_cmd, busy;
  pi_act_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .act  (pi_act),
    .rise (pi_rise)
  );
  // A strobe carrying neither a read nor a write command is not a memory access.
  assign pi_cmd = pi_rise & pi_mem & (pi_we | pi_oe);
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cyc_d = cyc_q;
    pend_d = pend_q;
    ovf_d = ovf_q;
    ack_d = 1'b0;
    we_d = we_q;
    sel_d = sel_q;
    addr_d = addr_q;
    dout_d = dout_q;
    rq_we_d = rq_we_q;
    rq_sel_d = rq_sel_q;
    rq_addr_d = rq_addr_q;
    rq_dato_d = rq_dato_q;
    pi_dati_d = pi_dati_q;
    cart_dati_d = cart_dati_q;
    if (pi_cmd && pend_q) ovf_d = 1'b1;
    if (pi_cmd && !pend_q) begin
      pend_d = 1'b1;
      rq_we_d = pi_we;
      rq_sel_d = pi_addr[24:23];
      rq_addr_d = pi_addr[MEM_AW-1:0];
      rq_dato_d = pi_dato;
    end
    case (state_q)
      IDLE: begin
        if (pend_q && (last_q == G_CART || !cart_req)) begin
          state_d = PI;
          cyc_d = '0;
          we_d = rq_we_q;
          sel_d = rq_sel_q;
          addr_d = rq_addr_q;
          dout_d = rq_dato_q;
        end else if (cart_req) begin
          state_d = CART;
          cyc_d = '0;
          we_d = cart_we;
          sel_d = cart_sel;
          addr_d = cart_addr;
          dout_d = cart_dato;
        end
      end
      CART, PI: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == LAST) begin
          state_d = RECOV;
          last_d = (state_q == CART) ? G_CART : G_PI;
          ack_d = state_q == CART;
          pend_d = (state_q == PI) ? 1'b0 : pend_d;
          cart_dati_d = (state_q == CART && !we_q) ? mem_din : cart_dati_q;
          pi_dati_d = (state_q == PI && !we_q) ? mem_din : pi_dati_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= G_CART;
      cyc_q <= '0;
      pend_q <= 1'b0;
      ovf_q <= 1'b0;
      ack_q <= 1'b0;
      we_q <= 1'b0;
      sel_q <= '0;
      addr_q <= '0;
      dout_q <= '0;
      rq_we_q <= 1'b0;
      rq_sel_q <= '0;
      rq_addr_q <= '0;
      rq_dato_q <= '0;
      pi_dati_q <= 8'h00;
      cart_dati_q <= 8'h00;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cyc_q <= cyc_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
      ack_q <= ack_d;
      we_q <= we_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      rq_we_q <= rq_we_d;
      rq_sel_q <= rq_sel_d;
      rq_addr_q <= rq_addr_d;
      rq_dato_q <= rq_dato_d;
      pi_dati_q <= pi_dati_d;
      cart_dati_q <= cart_dati_d;
    end
  end
  // Strobes decode straight from the state register so an async reset drops them at once.
  assign busy = state_q == CART || state_q == PI;
  assign mem_ce = busy;
  assign mem_oe = busy & ~we_q;
  assign mem_we = busy & we_q;
  assign mem_sel = sel_q;
  assign mem_addr = addr_q;
  assign mem_dout = dout_q;
  assign pi_dati = pi_dati_q;
  assign pi_ovf = ovf_q;
  assign cart_dati = cart_dati_q;
  assign cart_ack = ack_q;
endmodule

// File: tb/tb_pi_mem_arb.sv
// tb_pi_mem_arb: directed scoreboard bench for pi_mem_arb; memory returns addr[7:0]^8'hD3 on reads.
module tb_pi_mem_arb;
  localparam int MEM_AW = 23, MEM_CYC = 4, SYNC_STG = 2;
  localparam int LAT_MAX = SYNC_STG + 1 + 2 * (MEM_CYC + 1);
  typedef struct packed {
    logic [1:0]  sel;
    logic [22:0] addr;
    logic        we;
    logic [7:0]  dout;
  } acc_t;
  logic clk = 1'b0;
  logic rst_n, pi_act, pi_we, pi_oe, pi_mem, pi_ovf, cart_req, cart_we, cart_ack;
  logic mem_ce, mem_oe, mem_we;
  logic [24:0] pi_addr;
  logic [7:0] pi_dato, pi_dati, cart_dato, cart_dati, mem_dout, mem_din;
  logic [1:0] cart_sel, mem_sel;
  logic [MEM_AW-1:0] cart_addr, mem_addr;
  int tests = 0, fails = 0, pi_cnt = 0;
  bit mon_en = 0, abort = 0;
  acc_t exp_q[$];
  logic [8:0] cart_q[$];
  assign mem_din = mem_addr[7:0] ^ 8'hD3;
  always #5 clk = ~clk;
  pi_mem_arb #(.MEM_AW(MEM_AW), .MEM_CYC(MEM_CYC), .SYNC_STG(SYNC_STG)) dut (
    .clk(clk), .rst_n(rst_n), .pi_act(pi_act), .pi_we(pi_we), .pi_oe(pi_oe), .pi_mem(pi_mem),
    .pi_addr(pi_addr), .pi_dato(pi_dato), .pi_dati(pi_dati), .pi_ovf(pi_ovf),
    .cart_req(cart_req), .cart_we(cart_we), .cart_sel(cart_sel), .cart_addr(cart_addr),
    .cart_dato(cart_dato), .cart_dati(cart_dati), .cart_ack(cart_ack), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din), .mem_ce(mem_ce),
    .mem_oe(mem_oe), .mem_we(mem_we)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (pi_cnt > 0) begin
      pi_cnt--;
      if (pi_cnt == 0) pi_act = 1'b0;
    end
  endtask
  task automatic pi_start(input logic mem, input logic we, input logic [24:0] addr, input logic [7:0] dato,
                          input int hold, input bit push);
    acc_t e;
    pi_mem = mem; pi_we = we; pi_oe = !we; pi_addr = addr; pi_dato = dato;
    pi_act = 1'b1; pi_cnt = hold;
    e.sel = addr[24:23]; e.addr = addr[22:0]; e.we = we; e.dout = dato;
    if (push) exp_q.push_back(e);
  endtask
  task automatic cart_issue(input logic we, input logic [1:0] sel, input logic [22:0] addr, input logic [7:0] dato);
    acc_t e;
    cart_we = we; cart_sel = sel; cart_addr = addr; cart_dato = dato; cart_req = 1'b1;
    e.sel = sel; e.addr = addr; e.we = we; e.dout = dato;
    exp_q.push_back(e);
    cart_q.push_back({we, addr[7:0] ^ 8'hD3});
  endtask
  task automatic wait_ack();
    int n = 0;
    do begin tick(); n++; end while (cart_ack !== 1'b1 && n < 40);
    chk("cart_ack_seen", cart_ack, 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mem_ce !== 1'b0) && n < 60) begin tick(); n++; end
    chk("idle_reached", exp_q.size(), 0);
    repeat (16) tick();
  endtask
  initial begin
    acc_t cur;
    logic [8:0] c;
    logic ce_prev = 1'b0;
    int len = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_ce === 1'b1 && !ce_prev) begin
          if (exp_q.size() == 0) chk("unexp_access", exp_q.size(), 1);
          else begin
            cur = exp_q.pop_front();
            len = 0;
            chk("acc_we", mem_we, cur.we);
            if (cur.we) chk("acc_dout", mem_dout, cur.dout);
          end
        end
        if (mem_ce === 1'b1) begin
          len++;
          chk("acc_sel_addr", {mem_sel, mem_addr}, {cur.sel, cur.addr});
          chk("acc_oe_we", {mem_oe, mem_we}, {!cur.we, cur.we});
        end else chk("idle_strobes", {mem_oe, mem_we}, 2'b00);
        if (mem_ce !== 1'b1 && ce_prev && !abort) chk("acc_len", len, MEM_CYC);
        if (cart_ack === 1'b1) begin
          if (cart_q.size() == 0) chk("unexp_ack", cart_q.size(), 1);
          else begin
            c = cart_q.pop_front();
            if (!c[8]) chk("cart_dati", cart_dati, c[7:0]);
          end
        end
      end
      ce_prev = (mem_ce === 1'b1);
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    rst_n = 1'b1; pi_act = 0; pi_we = 0; pi_oe = 0; pi_mem = 0; pi_addr = '0; pi_dato = '0;
    cart_req = 0; cart_we = 0; cart_sel = '0; cart_addr = '0; cart_dato = '0;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_pi", {pi_dati, pi_ovf}, 0);
    chk("rst_cart", {cart_dati, cart_ack}, 0);
    chk("rst_mem_addr", {mem_sel, mem_addr}, 0);
    chk("rst_mem_ctl", {mem_dout, mem_ce, mem_oe, mem_we}, 0);
    rst_n = 1'b1;
    mon_en = 1;
    tick();
    pi_start(1, 1, 25'h0000123, 8'h5A, 3, 1);
    wait_idle();
    chk("pi_wr_dati", pi_dati, 8'h00);
    chk("idle_hold", {mem_sel, mem_addr, mem_dout}, {2'd0, 23'h000123, 8'h5A});
    pi_start(1, 0, 25'h1000010, 8'h00, 3, 1);
    n = 0;
    while (pi_dati !== 8'hC3 && n < 40) begin tick(); n++; end
    chk("pi_rd_dati", pi_dati, 8'hC3);
    chk("pi_rd_latency_ok", n <= LAT_MAX, 1);
    wait_idle();
    chk("pi_rd_sel_hold", mem_sel, 2'd2);
    chk("ovf_clear", pi_ovf, 0);
    cart_issue(0, 2'd0, 23'h000100, 8'h00);
    tick();
    pi_start(1, 1, 25'h0800044, 8'h77, 3, 1);
    wait_ack();
    cart_issue(1, 2'd2, 23'h000777, 8'h3C);
    wait_ack();
    cart_req = 1'b0;
    wait_idle();
    chk("contention_ovf", pi_ovf, 0);
    pi_start(1, 1, 25'h0800055, 8'h11, 2, 1);
    repeat (4) tick();
    pi_start(1, 1, 25'h0800077, 8'h22, 2, 0);
    wait_idle();
    chk("ovf_set", pi_ovf, 1);
    chk("ovf_first_kept", {mem_addr, mem_dout}, {23'h000055, 8'h11});
    pi_start(0, 0, 25'h0000321, 8'h00, 3, 0);
    wait_idle();
    chk("sys_dati_hold", pi_dati, 8'hC3);
    chk("ovf_sticky", pi_ovf, 1);
    cart_issue(0, 2'd0, 23'h000200, 8'h00);
    n = 0;
    while (mem_ce !== 1'b1 && n < 20) begin tick(); n++; end
    chk("cart_grant", mem_ce, 1);
    abort = 1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_strobes", {mem_ce, mem_oe, mem_we}, 3'b000);
    cart_req = 1'b0;
    cart_q.delete();
    repeat (2) begin tick(); chk("rst_no_ack", cart_ack, 0); end
    chk("rst_clears", {pi_dati, pi_ovf}, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", {mem_ce, cart_ack}, 0);
    abort = 0;
    cart_issue(0, 2'd1, 23'h000300, 8'h00);
    wait_ack();
    cart_req = 1'b0;
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
